// File: rtl/sar_signed_search.sv
// Successive-approximation search for a signed value on an external comparator's A input.
// Optional EARLY_STOP_EN: an equal compare ends the search at once with Result = Trial.
module sar_signed_search #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             AgrB,
    input  logic             AeqB,
    input  logic             AltB,
    output logic [0:WIDTH-1] Trial,
    output logic             Busy,
    output logic             Done,
    output logic [0:WIDTH-1] Result,
    output logic             Err,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Bit 0 is the sign bit; flipping it maps offset-binary u to two's complement.
    localparam logic [0:WIDTH-1] SIGN       = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);

    state_t           state;
    logic [0:WIDTH-1] u;
    logic [0:WIDTH-1] mask;
    logic [3:0]       settle_cnt;

    logic             one_hot;
    logic             keep;
    logic [0:WIDTH-1] u_next;
    logic [0:WIDTH-1] mask_next;
    logic [0:WIDTH-1] trial_next;

    always_comb begin
        one_hot    = (AgrB ^ AeqB ^ AltB) & ~(AgrB & AeqB & AltB);
        keep       = AgrB | AeqB;
        u_next     = keep ? (u | mask) : u;
        mask_next  = mask >> 1;
        trial_next = (u_next | mask_next) ^ SIGN;
    end

    assign state_dbg = state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            u          <= '0;
            mask       <= '0;
            settle_cnt <= '0;
            Trial      <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Result     <= '0;
            Err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        u          <= '0;
                        mask       <= SIGN;
                        settle_cnt <= SETTLE_CNT;
                        Trial      <= '0;
                        Err        <= 1'b0;
                        Busy       <= 1'b1;
                        state      <= TRY;
                    end
                end
                TRY: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else if (!one_hot) begin
                        Err   <= 1'b1;
                        Trial <= '0;
                        mask  <= '0;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= FIN;
`ifdef EARLY_STOP_EN
                    end else if (AeqB) begin
                        Result <= Trial;
                        Trial  <= '0;
                        mask   <= '0;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        state  <= FIN;
`endif
                    end else if (mask[WIDTH-1]) begin
                        Result <= u_next ^ SIGN;
                        Trial  <= '0;
                        mask   <= '0;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        state  <= FIN;
                    end else begin
                        u          <= u_next;
                        mask       <= mask_next;
                        Trial      <= trial_next;
                        settle_cnt <= SETTLE_CNT;
                    end
                end
                FIN: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_signed_search.sv
// Bench for sar_signed_search: two instances (SETTLE 0 and 2) each driven by an ideal
// signed comparator, checked against an arithmetic binary-search reference.
module tb_sar_signed_search;

    localparam int W  = 4;
    localparam int S0 = 0;
    localparam int S1 = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start     [2];
    logic             gt        [2];
    logic             eq        [2];
    logic             lt        [2];
    logic [0:W-1]     trial     [2];
    logic             busy      [2];
    logic             done      [2];
    logic [0:W-1]     result    [2];
    logic             err       [2];
    logic [1:0]       state_dbg [2];
    int               a_val     [2];
    logic             force_bad [2];
    int               last_res  [2];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            gt[i] = force_bad[i] | (a_val[i] >  int'($signed(trial[i])));
            eq[i] = force_bad[i] | (a_val[i] == int'($signed(trial[i])));
            lt[i] = ~force_bad[i] & (a_val[i] < int'($signed(trial[i])));
        end
    end

    sar_signed_search #(.WIDTH(W), .SETTLE(S0)) dut0 (
        .Clk(clk), .Reset(rst), .Start(start[0]),
        .AgrB(gt[0]), .AeqB(eq[0]), .AltB(lt[0]),
        .Trial(trial[0]), .Busy(busy[0]), .Done(done[0]),
        .Result(result[0]), .Err(err[0]), .state_dbg(state_dbg[0])
    );

    sar_signed_search #(.WIDTH(W), .SETTLE(S1)) dut1 (
        .Clk(clk), .Reset(rst), .Start(start[1]),
        .AgrB(gt[1]), .AeqB(eq[1]), .AltB(lt[1]),
        .Trial(trial[1]), .Busy(busy[1]), .Done(done[1]),
        .Result(result[1]), .Err(err[1]), .state_dbg(state_dbg[1])
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int settle_of(input int sel);
        return (sel == 0) ? S0 : S1;
    endfunction

    // k-th candidate of an ideal binary search over [-2^(W-1), 2^(W-1)-1].
    function automatic int exp_trial(input int a, input int k);
        int off, u, step, prefix;
        off    = 2 ** (W - 1);
        u      = a + off;
        step   = 2 ** (W - 1 - k);
        prefix = (u / (2 * step)) * (2 * step);
        return prefix + step - off;
    endfunction

    task automatic do_search(input int sel, input int a, input int bad_at, input int pulse_at);
        int  s1, stop_k, lat, exp_res;
        logic exp_err;
        s1     = settle_of(sel) + 1;
        stop_k = W - 1;
`ifdef EARLY_STOP_EN
        for (int k = W - 1; k >= 0; k--)
            if (exp_trial(a, k) == a) stop_k = k;
`endif
        if (bad_at >= 0 && bad_at <= stop_k) begin
            lat     = (bad_at + 1) * s1;
            exp_err = 1'b1;
            exp_res = last_res[sel];
        end else begin
            lat     = (stop_k + 1) * s1;
            exp_err = 1'b0;
            exp_res = a;
        end
        @(negedge clk);
        a_val[sel] = a;
        start[sel] = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            start[sel]     = (c == pulse_at);
            force_bad[sel] = (bad_at >= 0) && (c / s1 == bad_at);
            if (c < lat) begin
                check("trial", int'($signed(trial[sel])), exp_trial(a, c / s1));
                check("busy",  busy[sel], 1);
                check("done_early", done[sel], 0);
            end else begin
                check("done",   done[sel], 1);
                check("busy_fin", busy[sel], 0);
                check("result", int'($signed(result[sel])), exp_res);
                check("err",    err[sel], exp_err);
            end
        end
        @(negedge clk);
        start[sel]     = 1'b0;
        force_bad[sel] = 1'b0;
        check("done_pulse", done[sel], 0);
        check("busy_idle",  busy[sel], 0);
        check("trial_idle", int'($signed(trial[sel])), 0);
        check("result_hold", int'($signed(result[sel])), exp_res);
        check("err_hold",   err[sel], exp_err);
        last_res[sel] = exp_res;
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 2; i++) begin
            check("rst_trial",  int'($signed(trial[i])), 0);
            check("rst_busy",   busy[i], 0);
            check("rst_done",   done[i], 0);
            check("rst_result", int'($signed(result[i])), 0);
            check("rst_err",    err[i], 0);
            check("rst_state",  state_dbg[i], 0);
            last_res[i] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a, bad, pulse, s1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; a_val[i] = 0; force_bad[i] = 1'b0; last_res[i] = 0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        do_search(0, -8, -1, -1);
        do_search(0,  7, -1, -1);
        do_search(0, -4, -1, -1);
        do_search(0,  2,  1, -1);
        do_search(0,  0, -1,  1);
        do_search(0, -1, -1,  4);
        do_search(1,  5, -1, -1);
        do_search(1, -8, -1,  5);
        do_search(1,  3,  2, -1);

        // Reset while the third trial is on the bus: search abandoned, no Done.
        @(negedge clk);
        a_val[0] = 3;
        start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_done", done[0], 0);
        end

        for (int n = 0; n < 40; n++) begin
            a     = int'($urandom_range(0, 15)) - 8;
            bad   = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, W - 1)) : -1;
            s1    = settle_of(n % 2) + 1;
            pulse = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W * s1)) : -1;
            do_search(n % 2, a, bad, pulse);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
